// File: rtl/cpu0_mem_ctrl.sv
// CPU0 memory controller: byte-addressed big-endian RAM with wait states and a
// character-output FIFO mapped at IO_ADDR.
module cpu0_mem_ctrl #(
    parameter int unsigned MEM_BYTES   = 'h80000,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] IO_ADDR     = 32'h80000,
    parameter int unsigned IO_DEPTH    = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic        rw,
    input  logic [1:0]  m_size,
    input  logic [31:0] abus,
    input  logic [31:0] dbus_in,
    output logic [31:0] dbus_out,
    output logic        ready,
    output logic        err,
    output logic        io_valid,
    output logic [7:0]  io_data,
    input  logic        io_ready,
    output logic [2:0]  dbg_state
);
    // Handshakes: a request is taken when en=1 in IDLE; ready pulses for one
    // cycle when it completes (err/dbus_out valid then). The FIFO head pops on
    // any cycle where io_valid and io_ready are both 1.
    localparam int AW = $clog2(MEM_BYTES);
    localparam int PW = $clog2(IO_DEPTH);
    localparam int CW = $clog2(IO_DEPTH + 1);
    localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {IDLE, WAIT, ACCESS, IOPUSH, DONE} state_t;

    state_t        r_state;
    logic [3:0]    r_wait_cnt;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [1:0]    r_size;
    logic          r_rw;
    logic          r_ready;
    logic          r_err;
    logic [31:0]   r_dbus_out;
    logic [31:0]   r_pk_bytes;
    logic [2:0]    r_pk_left;

    logic [7:0]    r_mem [0:MEM_BYTES-1];
    logic [7:0]    r_fifo [0:IO_DEPTH-1];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_is_io;
    logic          w_oor;
    logic          w_mem_we;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic [AW-1:0] w_idx [4];
    logic [7:0]    w_wr_byte [4];
    logic [31:0]   w_rd_data;
    logic [31:0]   w_pk_bytes;
    logic [2:0]    w_pk_cnt;

    assign w_is_io  = (r_addr == IO_ADDR);
    assign w_oor    = ((33'(r_addr) + 33'(r_size) + 33'd1) > 33'(MEM_BYTES)) && !w_is_io;
    assign w_mem_we = !reset && (r_state == ACCESS) && !r_rw && !w_is_io && !w_oor;
    assign w_full   = (r_count == CW'(IO_DEPTH));
    assign w_pop    = (r_count != '0) && io_ready;
    assign w_push   = (r_state == IOPUSH) && (!w_full || w_pop);

    // m[addr] holds the most-significant byte of the sized field.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < 4; i++) begin
            w_idx[i]     = AW'(r_addr + 32'(i));
            w_wr_byte[i] = r_wdata[{2'(r_size - 2'(i)), 3'b000} +: 8];
            if (i <= int'(r_size)) begin
                w_rd_data = {w_rd_data[23:0], r_mem[w_idx[i]]};
            end
        end
    end

    // Bytes to emit for an IO write, packed low byte first, zero bytes dropped.
    always_comb begin
        w_pk_bytes = '0;
        w_pk_cnt   = '0;
        if (r_size == 2'd0) begin
            w_pk_bytes = {24'h0, r_wdata[7:0]};
            w_pk_cnt   = 3'd1;
        end else if (r_wdata[7:0] != 8'h0) begin
            for (int i = 0; i < 4; i++) begin
                if (i <= int'(r_size) && r_wdata[8*i +: 8] != 8'h0) begin
                    w_pk_bytes[{w_pk_cnt[1:0], 3'b000} +: 8] = r_wdata[8*i +: 8];
                    w_pk_cnt = w_pk_cnt + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_size     <= '0;
            r_rw       <= 1'b0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
            r_dbus_out <= '0;
            r_pk_bytes <= '0;
            r_pk_left  <= '0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_addr     <= abus;
                        r_wdata    <= dbus_in;
                        r_size     <= m_size;
                        r_rw       <= rw;
                        r_wait_cnt <= '0;
                        r_state    <= (WAIT_STATES > 0) ? WAIT : ACCESS;
                    end
                end
                WAIT: begin
                    if (r_wait_cnt == WAIT_LAST) r_state <= ACCESS;
                    else r_wait_cnt <= r_wait_cnt + 4'd1;
                end
                ACCESS: begin
                    if (r_rw) begin
                        if (w_is_io) r_dbus_out <= 32'(r_count);
                        else if (w_oor) r_dbus_out <= '0;
                        else r_dbus_out <= w_rd_data;
                    end
                    if (!r_rw && w_is_io && w_pk_cnt != 3'd0) begin
                        r_pk_bytes <= w_pk_bytes;
                        r_pk_left  <= w_pk_cnt;
                        r_state    <= IOPUSH;
                    end else begin
                        r_ready <= 1'b1;
                        r_err   <= w_oor;
                        r_state <= DONE;
                    end
                end
                IOPUSH: begin
                    if (w_push) begin
                        r_pk_bytes <= r_pk_bytes >> 8;
                        r_pk_left  <= r_pk_left - 3'd1;
                        if (r_pk_left == 3'd1) begin
                            r_ready <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i <= int'(r_size)) r_mem[w_idx[i]] <= w_wr_byte[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_fifo[r_wr_ptr] <= r_pk_bytes[7:0];
    end

    // A pop needs a non-empty FIFO, so push+pop on empty only pushes.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign dbus_out  = r_dbus_out;
    assign ready     = r_ready;
    assign err       = r_err;
    assign io_valid  = (r_count != '0);
    assign io_data   = io_valid ? r_fifo[r_rd_ptr] : 8'h0;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_cpu0_mem_ctrl.sv
// Self-checking bench for cpu0_mem_ctrl: directed scenarios plus random traffic
// against a byte-level memory model and an expected FIFO byte queue.
module tb_cpu0_mem_ctrl;
    localparam longint   MEM_BYTES = 'h80000;
    localparam int       WS        = 1;
    localparam bit [31:0] IO_ADDR  = 32'h80000;

    logic        clock = 1'b0;
    logic        reset;
    logic        en;
    logic        rw;
    logic [1:0]  m_size;
    logic [31:0] abus;
    logic [31:0] dbus_in;
    logic [31:0] dbus_out;
    logic        ready;
    logic        err;
    logic        io_valid;
    logic [7:0]  io_data;
    logic        io_ready;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mdl_mem [longint];
    logic [7:0]  exp_q[$];
    logic [31:0] exp_dbus = 32'h0;

    cpu0_mem_ctrl #(
        .MEM_BYTES  (32'(MEM_BYTES)),
        .WAIT_STATES(WS),
        .IO_ADDR    (IO_ADDR),
        .IO_DEPTH   (8)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .en       (en),
        .rw       (rw),
        .m_size   (m_size),
        .abus     (abus),
        .dbus_in  (dbus_in),
        .dbus_out (dbus_out),
        .ready    (ready),
        .err      (err),
        .io_valid (io_valid),
        .io_data  (io_data),
        .io_ready (io_ready),
        .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mdl_byte(input longint a);
        return mdl_mem.exists(a) ? mdl_mem[a] : 8'h00;
    endfunction

    // Every byte leaving the FIFO must be the next one the model predicted.
    always @(negedge clock) begin
        if (!reset && io_valid && io_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL io_extra: observed=%0h expected=none", io_data);
            end
            if (exp_q.size() != 0) begin
                logic [7:0] eb;
                eb = exp_q.pop_front();
                checks++;
                assert (io_data === eb) else begin
                    errors++;
                    $error("FAIL io_byte: observed=%0h expected=%0h", io_data, eb);
                end
            end
        end
    end

    task automatic do_req(input logic rw_i, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] data, input string tag);
        int          n;
        longint      a;
        bit          is_io;
        bit          oor;
        logic [31:0] exp_rd;
        logic [7:0]  b;
        int          lat;
        bit          got;
        n      = int'(sz) + 1;
        a      = longint'(addr);
        is_io  = (addr == IO_ADDR);
        oor    = ((a + n) > MEM_BYTES) && !is_io;
        exp_rd = 32'h0;
        if (rw_i && is_io) io_ready = 1'b0;
        if (rw_i) begin
            if (is_io) exp_rd = 32'(exp_q.size());
            else if (!oor)
                for (int i = 0; i < n; i++) exp_rd = (exp_rd << 8) | 32'(mdl_byte(a + i));
            exp_dbus = exp_rd;
        end else if (is_io) begin
            for (int i = 0; i < n; i++) begin
                b = 8'(data >> (8 * i));
                if (sz == 2'd0 || (data[7:0] != 8'h0 && b != 8'h0)) exp_q.push_back(b);
            end
        end else if (!oor) begin
            for (int i = 0; i < n; i++) mdl_mem[a + i] = 8'(data >> (8 * (n - 1 - i)));
        end

        rw = rw_i; m_size = sz; abus = addr; dbus_in = data; en = 1'b1;
        lat = 0; got = 0;
        while (!got && lat < 200) begin
            @(posedge clock); #1;
            en = 1'b0;
            lat++;
            if (ready === 1'b1) got = 1;
        end
        check({tag, "_ready"}, 32'(got), 32'd1);
        if (!(!rw_i && is_io)) check({tag, "_lat"}, 32'(lat), 32'(WS + 2));
        check({tag, "_err"}, 32'(err), 32'(oor));
        check({tag, "_dbus"}, dbus_out, exp_dbus);
        @(posedge clock); #1;
        check({tag, "_valid"}, 32'(io_valid), 32'(exp_q.size() != 0));
    endtask

    task automatic drain(input string tag);
        int cyc;
        cyc = 0;
        io_ready = 1'b1;
        while ((exp_q.size() != 0 || io_valid) && cyc < 100) begin
            @(posedge clock); #1;
            cyc++;
        end
        check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_valid"}, 32'(io_valid), 32'd0);
    endtask

    initial begin
        bit saw;
        reset = 1'b1; en = 1'b0; rw = 1'b0; m_size = 2'd0;
        abus = 32'h0; dbus_in = 32'h0; io_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_io_valid", 32'(io_valid), 32'd0);
        check("rst_dbus", dbus_out, 32'd0);
        check("rst_io_data", 32'(io_data), 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Big-endian store/load and sized reads.
        do_req(1'b0, 2'd3, 32'd0, 32'h11223344, "w32");
        do_req(1'b1, 2'd3, 32'd0, 32'h0, "r32");
        check("r32_value", dbus_out, 32'h11223344);
        do_req(1'b1, 2'd0, 32'd0, 32'h0, "rb0");
        check("rb0_value", dbus_out, 32'h11);
        do_req(1'b1, 2'd0, 32'd1, 32'h0, "rb1");
        check("rb1_value", dbus_out, 32'h22);
        do_req(1'b1, 2'd1, 32'd2, 32'h0, "r16");
        check("r16_value", dbus_out, 32'h3344);
        do_req(1'b0, 2'd1, 32'd0, 32'hFFFF_ABCD, "w16");
        do_req(1'b1, 2'd2, 32'd0, 32'h0, "r24");

        for (int k = 1; k < 16; k++) do_req(1'b0, 2'd3, 32'(4 * k), $urandom(), "init");
        do_req(1'b0, 2'd3, 32'(MEM_BYTES - 4), $urandom(), "init_hi");
        do_req(1'b1, 2'd3, 32'(MEM_BYTES - 4), 32'h0, "rd_hi");

        // Range boundary: field would end past the last byte.
        do_req(1'b1, 2'd3, 32'(MEM_BYTES - 2), 32'h0, "oor_rd");
        check("oor_rd_zero", dbus_out, 32'h0);
        do_req(1'b0, 2'd1, 32'(MEM_BYTES - 1), 32'h5555, "oor_wr");
        do_req(1'b1, 2'd3, 32'(MEM_BYTES - 4), 32'h0, "hi_intact");

        // String-style IO write: zero bytes never reach the FIFO.
        io_ready = 1'b1;
        do_req(1'b0, 2'd3, IO_ADDR, 32'h00000A41, "io_str");
        drain("io_str_drain");
        do_req(1'b0, 2'd3, IO_ADDR, 32'h41424300, "io_lead0");
        do_req(1'b0, 2'd2, IO_ADDR, 32'hFF430044, "io_skip");
        drain("io_skip_drain");

        // Fill the FIFO, then a ninth push must stall until one pop.
        io_ready = 1'b0;
        for (int k = 0; k < 8; k++)
            do_req(1'b0, 2'd0, IO_ADDR, (k == 3) ? 32'h0 : 32'($urandom_range(1, 255)), "io_fill");
        do_req(1'b1, 2'd0, IO_ADDR, 32'h0, "io_cnt_full");
        rw = 1'b0; m_size = 2'd0; abus = IO_ADDR; dbus_in = 32'h5A; en = 1'b1;
        exp_q.push_back(8'h5A);
        saw = 0;
        repeat (12) begin
            @(posedge clock); #1;
            en = 1'b0;
            if (ready) saw = 1;
        end
        check("stall_noready", 32'(saw), 32'd0);
        check("stall_io_valid", 32'(io_valid), 32'd1);
        io_ready = 1'b1;
        @(posedge clock); #1;
        io_ready = 1'b0;
        check("stall_release_ready", 32'(ready), 32'd1);
        check("stall_release_err", 32'(err), 32'd0);
        @(posedge clock); #1;
        do_req(1'b1, 2'd3, IO_ADDR, 32'h0, "io_cnt_after");
        drain("stall_drain");

        // Reset while a write waits: no completion, memory untouched.
        do_req(1'b1, 2'd3, 32'd4, 32'h0, "pre_rst_rd");
        io_ready = 1'b0;
        do_req(1'b0, 2'd0, IO_ADDR, 32'h77, "pre_rst_io");
        rw = 1'b0; m_size = 2'd3; abus = 32'd8; dbus_in = 32'hDEADBEEF; en = 1'b1;
        @(posedge clock); #1;
        en = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        exp_q.delete();
        exp_dbus = 32'h0;
        check("wrst_ready", 32'(ready), 32'd0);
        check("wrst_err", 32'(err), 32'd0);
        check("wrst_io_valid", 32'(io_valid), 32'd0);
        check("wrst_dbus", dbus_out, 32'd0);
        check("wrst_io_data", 32'(io_data), 32'd0);
        reset = 1'b0;
        saw = 0;
        repeat (6) begin
            @(posedge clock); #1;
            if (ready) saw = 1;
        end
        check("wrst_noready", 32'(saw), 32'd0);
        do_req(1'b1, 2'd3, 32'd8, 32'h0, "wrst_mem8");

        // Random traffic across RAM, the top edge, out-of-range and IO.
        for (int k = 0; k < 80; k++) begin
            int          sel;
            logic [1:0]  sz;
            logic        r;
            logic [31:0] ad;
            logic [31:0] dt;
            io_ready = 1'b1;
            sel = $urandom_range(0, 9);
            sz  = 2'($urandom_range(0, 3));
            r   = 1'($urandom_range(0, 1));
            dt  = $urandom();
            if (sel <= 5) ad = 32'($urandom_range(0, 63 - int'(sz)));
            else if (sel == 6) ad = 32'(MEM_BYTES - 4) + 32'($urandom_range(0, 3));
            else if (sel == 7) ad = ($urandom_range(0, 1) == 1) ? 32'(MEM_BYTES + 8) : 32'hFFFF_FFFE;
            else begin
                ad = IO_ADDR;
                r  = (sel == 9);
                for (int j = 0; j < 4; j++)
                    dt[8*j +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            end
            do_req(r, sz, ad, dt, "rnd");
        end
        drain("final_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cpu0_mem_ctrl.md
CPU0_MEM_CTRL -- requirements
Module: cpu0_mem_ctrl

Interface
REQ-001 Parameter MEM_BYTES, default 'h80000, SHALL set the size of the byte-addressed memory array.
REQ-002 Parameter WAIT_STATES, default 1, range 0..15, SHALL set the extra cycles before each access completes.
REQ-003 Parameter IO_ADDR, default 'h80000, SHALL set the character-output port address.
REQ-004 Parameter IO_DEPTH, default 8, power of 2, SHALL set the output FIFO depth.
REQ-005 Port clock, input, 1: the only clock; all state SHALL change on its rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port en, input, 1: request valid.
REQ-008 Port rw, input, 1: 1=read, 0=write.
REQ-009 Port m_size, input, 2: 00 BYTE, 01 INT16, 10 INT24, 11 INT32.
REQ-010 Port abus, input, 32: byte address.
REQ-011 Port dbus_in, input, 32: write data, right-aligned.
REQ-012 Port dbus_out, output, 32: read data, right-aligned and zero-extended.
REQ-013 Port ready, output, 1: one-cycle completion pulse.
REQ-014 Port err, output, 1: out-of-range flag, valid while ready=1.
REQ-015 Port io_valid, output, 1: FIFO non-empty.
REQ-016 Port io_data, output, 8: FIFO head byte.
REQ-017 Port io_ready, input, 1: consumer pops the head when io_valid and io_ready are both 1.

Function
REQ-018 States SHALL be IDLE, WAIT, ACCESS, IOPUSH and DONE.
REQ-019 In IDLE with en=1, the block SHALL latch abus, dbus_in, m_size and rw, then go to WAIT (WAIT_STATES>0) or ACCESS (WAIT_STATES=0).
REQ-020 WAIT SHALL count WAIT_STATES cycles, then go to ACCESS.
REQ-021 ACCESS SHALL perform the operation and go to DONE; an IO write with bytes to emit SHALL go to IOPUSH instead.
REQ-022 DONE SHALL assert ready for exactly one cycle, then return to IDLE.
REQ-023 Latency from accept to ready SHALL be WAIT_STATES+2 cycles, excluding IOPUSH cycles.
REQ-024 en held high in IDLE after DONE SHALL start a new request, so the requester drops en in the ready cycle.
REQ-025 Byte order SHALL be big-endian: m[addr] is the most-significant byte of the sized field.
REQ-026 A write SHALL store only the lowest n bytes of the latched data, where n = m_size+1.
REQ-027 dbus_out SHALL update at ready and hold until the next completed read.
REQ-028 Writes SHALL leave dbus_out unchanged.
REQ-029 An access is out of range when addr+n > MEM_BYTES and addr != IO_ADDR.
REQ-030 For an out-of-range access: memory SHALL be unchanged, err=1 with ready, and read data SHALL be 0.
REQ-031 A BYTE write to IO_ADDR SHALL push dbus_in[7:0], including 0x00.
REQ-032 An INT32 write to IO_ADDR SHALL push bytes [7:0],[15:8],[23:16],[31:24] in that order.
REQ-033 For an INT32 IO write, zero bytes SHALL be skipped, and nothing SHALL be pushed if [7:0]=0.
REQ-034 INT16 and INT24 IO writes SHALL follow the INT32 rule restricted to their n bytes.
REQ-035 IOPUSH SHALL push one byte per cycle and stall while the FIFO is full.
REQ-036 A push SHALL be allowed when full if a pop occurs in the same cycle.
REQ-037 A read at IO_ADDR SHALL return {24'h0, 4'h0, count} for IO_DEPTH <= 8, with err=0.
REQ-038 A simultaneous push and pop on an empty FIFO SHALL only push; the byte becomes visible next cycle.
REQ-039 FIFO pointers SHALL wrap modulo IO_DEPTH, and count SHALL range 0..IO_DEPTH.

Reset
REQ-040 When reset=1 at a clock edge, state SHALL go to IDLE and ready, err, io_valid, dbus_out and io_data SHALL all be 0.
REQ-041 When reset=1 at a clock edge, the FIFO SHALL become empty and the wait counter SHALL clear.
REQ-042 Reset SHALL take priority over all requests.
REQ-043 Reset in WAIT or IDLE SHALL abort the request with no memory write and no ready.
REQ-044 Reset in IOPUSH SHALL drop the remaining bytes.
REQ-045 Memory contents SHALL NOT be reset.

Verification
REQ-046 WAIT_STATES=1: write INT32 'h11223344 to addr 0, then read it -> ready 3 cycles after each accept, m[0..3]=11,22,33,44, dbus_out='h11223344.
REQ-047 Read BYTE at addr 1 and INT16 at addr 2 after REQ-046 -> dbus_out='h22, then 'h3344.
REQ-048 INT32 write 'h00000A41 to IO_ADDR with io_ready=1 -> FIFO emits 'h41 then 'h0A; no 00 bytes emitted.
REQ-049 io_ready=0 with IO_DEPTH=8, nine BYTE IO writes -> ninth write stalls in IOPUSH with ready=0; one pop -> ninth completes.
REQ-050 INT32 read at MEM_BYTES-2 -> ready=1, err=1, dbus_out=0.
REQ-051 Reset asserted in WAIT of a write to addr 8 -> no ready, m[8..11] unchanged, all outputs 0.
